regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write-back port (reg_we / wb_addr / wb_data) among three write-back requesters: ALU, load unit and multi-cycle mul/div unit.
- Sits between the execute/memory stages and the register file.
- Each requester uses a valid/ready handshake.
- The block grants at most one write per cycle under a round-robin or fixed-priority policy, drops writes to r0, and registers the selected write onto the register-file port.

---
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port among the
// ALU (0), load unit (1) and mul/div unit (2). One grant per cycle, chosen by
// round-robin or fixed priority, registered onto the write-back port.
module regfile_wb_arbiter #(
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [2:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        req_ready,
    output logic              reg_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        grant_id
);

    localparam logic [1:0] NO_GRANT = 2'd3;

    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        ptr_eff;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [1:0]        grant_id_q, grant_id_d;

    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [2:0]        cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Search for the first valid requester starting at the pointer; 3 is treated as 0.
    always_comb begin
        ptr_eff     = (RR_EN && ptr_q != 2'd3) ? ptr_q : 2'd0;
        grant_valid = 1'b0;
        grant_idx   = NO_GRANT;
        cand        = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, ptr_eff} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant_valid && req_valid[cand[1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
        if (rst || freeze) begin
            grant_valid = 1'b0;
            grant_idx   = NO_GRANT;
        end
        req_ready = grant_valid ? (3'b001 << grant_idx) : 3'b000;
    end

    // Route the granted requester's address and data toward the output stage.
    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        case (grant_idx)
            2'd1: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            2'd2: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
        endcase
    end

    // Next-state for pointer and write-back registers; r0 writes consume the slot but never enable.
    always_comb begin
        ptr_d      = ptr_eff;
        reg_we_d   = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        grant_id_d = NO_GRANT;
        if (grant_valid) begin
            if (RR_EN) begin
                ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end
            reg_we_d   = (sel_addr != '0);
            wb_addr_d  = sel_addr;
            wb_data_d  = sel_data;
            grant_id_d = grant_idx;
        end
        if (!RR_EN) begin
            ptr_d = 2'd0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 2'd0;
            reg_we_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            grant_id_q <= NO_GRANT;
        end else begin
            ptr_q      <= ptr_d;
            reg_we_q   <= reg_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    // A write presented in a cycle where reset is asserted is discarded.
    assign reg_we   = reg_we_q & ~rst;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a round-robin and a fixed-priority instance,
// each with its own requesters, checked against a rule-level model via a scoreboard.
module tb_regfile_wb_arbiter;

    typedef struct {
        int          gid;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          is_reset;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic [2:0]  valid_s [2];
    logic [4:0]  addr_s  [2][3];
    logic [31:0] data_s  [2][3];
    logic [2:0]  ready_s [2];
    logic        we_s    [2];
    logic [4:0]  wa_s    [2];
    logic [31:0] wd_s    [2];
    logic [1:0]  gid_s   [2];

    int          total = 0;
    int          bad = 0;
    int          m_ptr [2];
    logic [4:0]  exp_addr [2];
    logic [31:0] exp_data [2];
    entry_t      q0 [$];
    entry_t      q1 [$];

    regfile_wb_arbiter #(.RR_EN(1'b1), .ADDR_W(5), .DATA_W(32)) dut_rr (
        .clk(clk), .rst(rst), .freeze(freeze), .req_valid(valid_s[0]),
        .req_addr0(addr_s[0][0]), .req_data0(data_s[0][0]),
        .req_addr1(addr_s[0][1]), .req_data1(data_s[0][1]),
        .req_addr2(addr_s[0][2]), .req_data2(data_s[0][2]),
        .req_ready(ready_s[0]), .reg_we(we_s[0]), .wb_addr(wa_s[0]),
        .wb_data(wd_s[0]), .grant_id(gid_s[0])
    );

    regfile_wb_arbiter #(.RR_EN(1'b0), .ADDR_W(5), .DATA_W(32)) dut_fp (
        .clk(clk), .rst(rst), .freeze(freeze), .req_valid(valid_s[1]),
        .req_addr0(addr_s[1][0]), .req_data0(data_s[1][0]),
        .req_addr1(addr_s[1][1]), .req_data1(data_s[1][1]),
        .req_addr2(addr_s[1][2]), .req_data2(data_s[1][2]),
        .req_ready(ready_s[1]), .reg_we(we_s[1]), .wb_addr(wa_s[1]),
        .wb_data(wd_s[1]), .grant_id(gid_s[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rule-level choice: instance 0 searches from its pointer, instance 1 from requester 0.
    function automatic int pick(int d, logic [2:0] v, logic f, logic r);
        int base;
        if (r || f) return 3;
        base = (d == 0) ? m_ptr[0] : 0;
        for (int k = 0; k < 3; k++) begin
            if (v[(base + k) % 3]) return (base + k) % 3;
        end
        return 3;
    endfunction

    task automatic setReq(input int i, input logic [4:0] a, input logic [31:0] dt);
        for (int d = 0; d < 2; d++) begin
            if (!valid_s[d][i]) begin
                valid_s[d][i] = 1'b1;
                addr_s[d][i]  = a;
                data_s[d][i]  = dt;
            end
        end
    endtask

    // One cycle: called just after a rising edge, returns just after the next one.
    task automatic applyStimulus(input logic f, input logic r);
        logic [2:0] done [2];
        entry_t     e;
        int         g;
        freeze = f;
        rst    = r;
        #3;
        for (int d = 0; d < 2; d++) begin
            g = pick(d, valid_s[d], f, r);
            checkOutput($sformatf("d%0d_ready", d), {29'd0, ready_s[d]},
                        (g == 3) ? 32'd0 : (32'd1 << g));
            e.gid      = g;
            e.is_reset = r;
            e.addr     = (g == 3) ? 5'd0 : addr_s[d][g];
            e.data     = (g == 3) ? 32'd0 : data_s[d][g];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (r) m_ptr[d] = 0;
            else if (d == 0 && g != 3) m_ptr[d] = (g + 1) % 3;
            done[d] = valid_s[d] & ready_s[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) valid_s[d] = valid_s[d] & ~done[d];
    endtask

    task automatic monDut(input int d);
        entry_t e;
        logic   exp_we;
        int     exp_gid;
        if (d == 0 && q0.size() == 0) return;
        if (d == 1 && q1.size() == 0) return;
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        exp_we  = 1'b0;
        exp_gid = 3;
        if (e.is_reset) begin
            exp_addr[d] = 5'd0;
            exp_data[d] = 32'd0;
        end else if (e.gid != 3) begin
            exp_addr[d] = e.addr;
            exp_data[d] = e.data;
            exp_gid     = e.gid;
            exp_we      = (e.addr != 5'd0) && !rst;
        end
        checkOutput($sformatf("d%0d_reg_we", d), {31'd0, we_s[d]}, {31'd0, exp_we});
        checkOutput($sformatf("d%0d_wb_addr", d), {27'd0, wa_s[d]}, {27'd0, exp_addr[d]});
        checkOutput($sformatf("d%0d_wb_data", d), wd_s[d], exp_data[d]);
        checkOutput($sformatf("d%0d_grant_id", d), {30'd0, gid_s[d]}, 32'(exp_gid));
    endtask

    // Monitor: after every edge, compare each instance's outputs with the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            monDut(0);
            monDut(1);
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [4:0] a;
        for (int d = 0; d < 2; d++) begin
            valid_s[d]  = 3'b000;
            m_ptr[d]    = 0;
            exp_addr[d] = 5'd0;
            exp_data[d] = 32'd0;
            for (int i = 0; i < 3; i++) begin
                addr_s[d][i] = 5'd0;
                data_s[d][i] = 32'd0;
            end
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);

        setReq(0, 5'd5, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        setReq(0, 5'd1, 32'hA000_0001);
        setReq(1, 5'd2, 32'hA000_0002);
        setReq(2, 5'd3, 32'hA000_0003);
        repeat (4) applyStimulus(1'b0, 1'b0);

        setReq(2, 5'd12, 32'hB000_0002);
        setReq(1, 5'd11, 32'hB000_0001);
        applyStimulus(1'b0, 1'b0);
        setReq(0, 5'd10, 32'hB000_0000);
        repeat (4) applyStimulus(1'b0, 1'b0);

        setReq(1, 5'd0, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        setReq(0, 5'd20, 32'hC000_0000);
        setReq(2, 5'd22, 32'hC000_0002);
        repeat (3) applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);

        setReq(2, 5'd7, 32'hD000_0007);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        setReq(0, 5'd4, 32'hE000_0000);
        setReq(1, 5'd4, 32'hE000_0001);
        setReq(2, 5'd4, 32'hE000_0002);
        repeat (4) applyStimulus(1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!valid_s[d][i] && ($urandom_range(0, 1) == 1)) begin
                        a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                        valid_s[d][i] = 1'b1;
                        addr_s[d][i]  = a;
                        data_s[d][i]  = $urandom;
                    end
                end
            end
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
        end

        for (int d = 0; d < 2; d++) valid_s[d] = 3'b000;
        repeat (2) applyStimulus(1'b0, 1'b0);
        #5;
        checkOutput("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
